// File: rtl/axis_demux_1x4.sv
// -----------------------------------------------------------------------------
// axis_demux_1x4
//
// Purpose:
//   One AXI-Stream slave fanned out to M_COUNT AXI-Stream masters. Each frame
//   is steered by the tdest seen on its first beat, and that route is held
//   until the tlast beat. A frame whose tdest is not a valid port index
//   (tdest >= M_COUNT) is accepted at full rate and thrown away. Every master
//   port has a two-entry skid buffer (output register plus temp register). This
//   gives full throughput and registered outputs. It also keeps s_axis_tready
//   free of any combinational path from m_axis_tready.
//
// Ports:
//   clk              clock, all state on the rising edge
//   rst              asynchronous reset, active low
//   s_axis_*         slave stream: tdata, tkeep, tvalid, tready, tlast, tid,
//                    tdest, tuser
//   m_axis_*         master streams, port i in slice i of each bus; tdest is
//                    the received tdest, passed through unchanged
//   drop_count       (only with AXIS_DEMUX_DROP_CNT_EN) saturating count of
//                    discarded frames
//
// Build option:
//   AXIS_DEMUX_DROP_CNT_EN  adds the drop_count output and its counter.
// -----------------------------------------------------------------------------
module axis_demux_1x4 #(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int ID_ENABLE   = 1,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 3,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]           s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [ID_WIDTH-1:0]             s_axis_tid,
    input  logic [DEST_WIDTH-1:0]           s_axis_tdest,
    input  logic [USER_WIDTH-1:0]           s_axis_tuser,

    output logic [M_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic [M_COUNT-1:0]              m_axis_tvalid,
    input  logic [M_COUNT-1:0]              m_axis_tready,
    output logic [M_COUNT-1:0]              m_axis_tlast,
    output logic [M_COUNT*ID_WIDTH-1:0]     m_axis_tid,
    output logic [M_COUNT*DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [M_COUNT*USER_WIDTH-1:0]   m_axis_tuser
`ifdef AXIS_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]                     drop_count
`endif
);

    // Payload layout inside each skid register, LSB first:
    // last, user, dest, id, keep, data
    localparam int USER_LSB = 1;
    localparam int DEST_LSB = USER_LSB + USER_WIDTH;
    localparam int ID_LSB   = DEST_LSB + DEST_WIDTH;
    localparam int KEEP_LSB = ID_LSB + ID_WIDTH;
    localparam int DATA_LSB = KEEP_LSB + KEEP_WIDTH;
    localparam int PW       = DATA_LSB + DATA_WIDTH;

    // M_COUNT widened by one bit so the invalid-destination compare is
    // width-exact.
    localparam logic [DEST_WIDTH:0] M_COUNT_EXT = (DEST_WIDTH + 1)'(M_COUNT);

    // Frame routing state
    logic                  frame_active_reg;
    logic [DEST_WIDTH-1:0] sel_reg;
    logic                  drop_reg;

    logic [DEST_WIDTH-1:0] sel;
    logic                  drop;
    logic                  ready_sel;
    logic                  accept;
    logic [M_COUNT-1:0]    ready_int;

    logic [KEEP_WIDTH-1:0] keep_in;
    logic [ID_WIDTH-1:0]   id_in;
    logic [USER_WIDTH-1:0] user_in;
    logic [PW-1:0]         payload_in;

    // On the first beat of a frame the live tdest decides. After that the
    // route stored on that beat is used and later tdest values are ignored.
    assign sel  = frame_active_reg ? sel_reg  : s_axis_tdest;
    assign drop = frame_active_reg ? drop_reg : ({1'b0, s_axis_tdest} >= M_COUNT_EXT);

    // Pick the registered ready of the selected port. When drop is set, sel
    // may be out of range, and the drop term overrides the result anyway.
    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (sel == DEST_WIDTH'(i)) begin
                ready_sel = ready_int[i];
            end
        end
    end

    assign s_axis_tready = drop | ready_sel;
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Disabled sideband fields are forced to their fixed values here, so the
    // output registers carry them without any special handling.
    assign keep_in    = (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign id_in      = (ID_ENABLE   != 0) ? s_axis_tid   : {ID_WIDTH{1'b0}};
    assign user_in    = (USER_ENABLE != 0) ? s_axis_tuser : {USER_WIDTH{1'b0}};
    assign payload_in = {s_axis_tdata, keep_in, id_in, s_axis_tdest, user_in, s_axis_tlast};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_active_reg <= 1'b0;
            sel_reg          <= '0;
            drop_reg         <= 1'b0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                frame_active_reg <= 1'b0;
            end else if (!frame_active_reg) begin
                frame_active_reg <= 1'b1;
                sel_reg          <= s_axis_tdest;
                drop_reg         <= drop;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < M_COUNT; gi++) begin : g_port
            logic [PW-1:0] out_reg;
            logic [PW-1:0] temp_reg;
            logic          out_valid_reg;
            logic          temp_valid_reg;
            logic          ready_int_reg;
            logic          wr;

            assign wr            = accept & ~drop & (sel == DEST_WIDTH'(gi));
            assign ready_int[gi] = ready_int_reg;

            // ready_int is registered, so a beat written in this cycle is
            // covered by the spare temp entry. Ready is only withdrawn once
            // that spare entry is in use. Whenever ready_int_reg is 1, the
            // temp entry is empty.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_reg        <= '0;
                    temp_reg       <= '0;
                    out_valid_reg  <= 1'b0;
                    temp_valid_reg <= 1'b0;
                    ready_int_reg  <= 1'b0;
                end else begin
                    ready_int_reg <= m_axis_tready[gi] |
                                     (~temp_valid_reg & (~out_valid_reg | ~wr));
                    if (ready_int_reg) begin
                        if (m_axis_tready[gi] | ~out_valid_reg) begin
                            out_valid_reg <= wr;
                            if (wr) begin
                                out_reg <= payload_in;
                            end
                        end else begin
                            temp_valid_reg <= wr;
                            if (wr) begin
                                temp_reg <= payload_in;
                            end
                        end
                    end else if (m_axis_tready[gi]) begin
                        out_valid_reg  <= temp_valid_reg;
                        out_reg        <= temp_reg;
                        temp_valid_reg <= 1'b0;
                    end
                end
            end

            assign m_axis_tvalid[gi] = out_valid_reg;
            assign m_axis_tlast[gi]  = out_reg[0];
            assign m_axis_tuser[gi*USER_WIDTH +: USER_WIDTH] = out_reg[USER_LSB +: USER_WIDTH];
            assign m_axis_tdest[gi*DEST_WIDTH +: DEST_WIDTH] = out_reg[DEST_LSB +: DEST_WIDTH];
            assign m_axis_tid[gi*ID_WIDTH +: ID_WIDTH]       = out_reg[ID_LSB +: ID_WIDTH];
            assign m_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH] = out_reg[KEEP_LSB +: KEEP_WIDTH];
            assign m_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = out_reg[DATA_LSB +: DATA_WIDTH];
        end
    endgenerate

`ifdef AXIS_DEMUX_DROP_CNT_EN
    // Counted on the closing beat only. A one-beat dropped frame therefore
    // counts once.
    logic [15:0] drop_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count_reg <= '0;
        end else if (accept && drop && s_axis_tlast && (drop_count_reg != 16'hFFFF)) begin
            drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    assign drop_count = drop_count_reg;
`endif

endmodule

// File: doc/axis_demux_1x4.md
Name: axis_demux_1x4

Overview:
- Single AXI-Stream slave to four AXI-Stream masters; the return path of the 4x1 arbitrated switch.
- Routes each frame by the tdest sampled on its first beat and locks the route until tlast.
- Frames whose tdest >= M_COUNT are consumed and discarded.
- Each master port has a 2-entry skid register: full throughput, registered outputs.

Parameters:
- M_COUNT, 4, number of master ports (2..8).
- DATA_WIDTH, 8, tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8), carry tkeep; when 0, m_axis_tkeep is driven all-ones.
- KEEP_WIDTH, (DATA_WIDTH/8), tkeep width.
- ID_ENABLE, 1, carry tid; when 0, m_axis_tid is driven 0.
- ID_WIDTH, 8, tid width.
- DEST_WIDTH, 3, tdest width; must satisfy 2**DEST_WIDTH > M_COUNT so invalid destinations are representable.
- USER_ENABLE, 1, carry tuser; when 0, m_axis_tuser is driven 0.
- USER_WIDTH, 1, tuser width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input keep.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of frame.
- s_axis_tid  in  ID_WIDTH  stream id.
- s_axis_tdest  in  DEST_WIDTH  destination port index.
- s_axis_tuser  in  USER_WIDTH  sideband.
- m_axis_tdata  out  M_COUNT*DATA_WIDTH  per-port data; port i occupies slice i.
- m_axis_tkeep  out  M_COUNT*KEEP_WIDTH  per-port keep.
- m_axis_tvalid  out  M_COUNT  per-port valid.
- m_axis_tready  in  M_COUNT  per-port ready.
- m_axis_tlast  out  M_COUNT  per-port last.
- m_axis_tid  out  M_COUNT*ID_WIDTH  per-port id.
- m_axis_tdest  out  M_COUNT*DEST_WIDTH  per-port dest; the received tdest is passed unchanged.
- m_axis_tuser  out  M_COUNT*USER_WIDTH  per-port user.

Behaviour:
- State: frame_active (0 = IDLE, 1 = IN_FRAME), sel_reg[DEST_WIDTH-1:0], drop_reg.
- Effective select:
  - sel = frame_active ? sel_reg : s_axis_tdest
  - drop = frame_active ? drop_reg : (s_axis_tdest >= M_COUNT)
- s_axis_tready = drop ? 1 : ready_int[sel]. ready_int[i] is a registered per-port skid-ready. tready does not depend combinationally on m_axis_tready.
- Accepted beat (s_axis_tvalid & s_axis_tready):
  - If not drop: the beat is written to port sel's skid; other ports are untouched.
  - If drop: the beat is discarded.
  - If tlast=1: frame_active <= 0.
  - Else if frame_active=0: frame_active <= 1, sel_reg <= s_axis_tdest, drop_reg <= drop.
- A single-beat frame (tlast on the first beat) never enters IN_FRAME.
- Route lock: s_axis_tdest changing mid-frame is ignored.
- A port that is not ready stalls the input; there is no head-of-line bypass to other ports.
- Skid per port (output reg + temp reg):
  - ready_int_next = m_axis_tready[i] | (~temp_valid & (~out_valid | ~write_this_cycle)).
  - Write with the output reg empty or consumed: goes to the output reg. Otherwise the write goes to the temp reg.
  - Output consumed with temp valid: temp moves to the output reg.
- Latency: 1 cycle from input acceptance to m_axis_tvalid. Sustains 1 beat/clk per port with m_axis_tready held high.
- Reset (rst=0), asynchronous:
  - frame_active=0, sel_reg=0, drop_reg=0.
  - All m_axis_tvalid=0, all temp valid=0, ready_int=0; other output data regs 0.
  - s_axis_tready is 0 for dests < M_COUNT and 1 for invalid dests.
  - ready_int goes to 1 on the first clock after release.
- Reset mid-frame: skid contents are lost. The next accepted beat is treated as a frame start, so its tdest is sampled.
- Outputs hold data stable while tvalid=1 and tready=0 (AXI-S rule).

Optional Feature:
- Macro: AXIS_DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port drop_count [15:0], reset 0.
  - Increments by 1 on the accepted tlast beat of each dropped frame; a single-beat dropped frame counts once.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; no behaviour change otherwise.

Test Plan:
- Setup: after reset release, all m_axis_tready=1.
- Dest 2: send 3-beat frame tdest=2, data 0xA1,0xA2,0xA3 -> port 2 emits A1,A2,A3 on consecutive cycles, first 1 cycle after input; tlast only on A3; ports 0,1,3 tvalid stay 0.
- Route lock: send 4-beat frame with tdest=1 on beat 0 and tdest=3 on beats 1-3 -> all 4 beats on port 1 with m_axis_tdest=1,3,3,3; port 3 sees nothing.
- Backpressure: hold m_axis_tready[0]=0 during 4-beat frame to port 0 -> s_axis_tready falls after 2 beats are accepted (out + temp); release -> all 4 beats delivered in order, no loss or duplication.
- Invalid dest: frame tdest=5 (2 beats), then tdest=0 (1 beat, 0x55) -> dropped frame sees tready=1 every cycle, no port valid; port 0 gets 0x55 with tlast=1; drop_count=1 if AXIS_DEMUX_DROP_CNT_EN.
- Reset mid-frame: assert rst=0 after beat 1 of a 3-beat frame to port 3 -> all m_axis_tvalid=0 immediately. After release, the next beat with tdest=0 routes to port 0.
- Back-to-back single-beat frames: tdest 0,1,2,3,0 on consecutive cycles -> one beat on each port in that order, 1-cycle latency, no bubbles.
